// File: rtl/sub256mod.sv
// sub256mod: serial 256-bit modular subtraction, dataz = (datax - datay) mod modz.
// The operation runs as four 64-bit borrow limbs (SUB), then four 64-bit
// conditional add-back limbs (CORR) when the subtraction underflowed.
// Optional build macro SUB256MOD_FASTPATH_EN: skip CORR when no underflow.
module sub256mod #(
  parameter logic [255:0] modz = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [255:0] datax,
  input  logic [255:0] datay,
  input  logic         update,
  output logic [255:0] dataz,
  output logic         done,
  output logic         busy
);

  localparam int DATA_W = 256;
  localparam int LIMB_W = 64;

  typedef enum logic [1:0] {IDLE, SUB, CORR} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   x_r;
  logic [DATA_W-1:0]   y_r;
  logic [DATA_W-1:0]   acc_r;
  logic [1:0]          cnt;
  logic                borrow;
  logic                carry;
  logic [7:0]          idx;
  logic                last_limb;
  logic [LIMB_W:0]     sub_w;
  logic [LIMB_W:0]     corr_w;
  logic                ld_op;
  logic                finish;
  logic [DATA_W-1:0]   fin_val;

  // One limb of x - y - bin; bit 64 of the result is the borrow out.
  function automatic logic [LIMB_W:0] limb_sub(input logic [LIMB_W-1:0] a,
                                               input logic [LIMB_W-1:0] b,
                                               input logic              bin);
    limb_sub = {1'b0, a} - {1'b0, b} - {{LIMB_W{1'b0}}, bin};
  endfunction

  // One limb of a + b + cin; bit 64 of the result is the carry out.
  function automatic logic [LIMB_W:0] limb_add(input logic [LIMB_W-1:0] a,
                                               input logic [LIMB_W-1:0] b,
                                               input logic              cin);
    limb_add = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
  endfunction

  assign idx       = {cnt, 6'd0};
  assign last_limb = (cnt == 2'd3);
  // During CORR, borrow still holds the final SUB borrow and selects the add-back.
  assign sub_w     = limb_sub(x_r[idx +: LIMB_W], y_r[idx +: LIMB_W], borrow);
  assign corr_w    = limb_add(acc_r[idx +: LIMB_W], modz[idx +: LIMB_W] & {LIMB_W{borrow}}, carry);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (update) state_nxt = SUB;
      SUB: begin
        if (last_limb) begin
`ifdef SUB256MOD_FASTPATH_EN
          if (!sub_w[LIMB_W]) state_nxt = IDLE;
          else                state_nxt = CORR;
`else
          state_nxt = CORR;
`endif
        end
      end
      CORR: if (last_limb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode: operand load, completion strobe and final result assembly
  always_comb begin
    ld_op   = 1'b0;
    finish  = 1'b0;
    fin_val = {corr_w[LIMB_W-1:0], acc_r[DATA_W-LIMB_W-1:0]};
    case (state)
      IDLE: ld_op = update;
      SUB: begin
`ifdef SUB256MOD_FASTPATH_EN
        if (last_limb && !sub_w[LIMB_W]) begin
          finish  = 1'b1;
          fin_val = {sub_w[LIMB_W-1:0], acc_r[DATA_W-LIMB_W-1:0]};
        end
`endif
      end
      CORR: finish = last_limb;
      default: ;
    endcase
  end

  // Datapath: operand capture, limb-serial subtract / add-back, result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_r    <= '0;
      y_r    <= '0;
      acc_r  <= '0;
      cnt    <= 2'd0;
      borrow <= 1'b0;
      carry  <= 1'b0;
      dataz  <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= finish;
      if (ld_op) begin
        x_r    <= datax;
        y_r    <= datay;
        acc_r  <= '0;
        cnt    <= 2'd0;
        borrow <= 1'b0;
        carry  <= 1'b0;
        busy   <= 1'b1;
      end else if (state == SUB) begin
        acc_r[idx +: LIMB_W] <= sub_w[LIMB_W-1:0];
        borrow               <= sub_w[LIMB_W];
        cnt                  <= cnt + 2'd1;
      end else if (state == CORR) begin
        acc_r[idx +: LIMB_W] <= corr_w[LIMB_W-1:0];
        carry                <= corr_w[LIMB_W];
        cnt                  <= cnt + 2'd1;
      end
      if (finish) begin
        dataz <= fin_val;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sub256mod.sv
// tb_sub256mod: scoreboard bench for sub256mod (directed vectors).
// Build with SUB256MOD_FASTPATH_EN defined to expect the short no-borrow latency.
module tb_sub256mod;

  localparam logic [255:0] N  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] N1 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364140;
  localparam logic [255:0] N2 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D036413F;
  localparam logic [255:0] NP1 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364142;
`ifdef SUB256MOD_FASTPATH_EN
  localparam int FASTLAT = 4;
`else
  localparam int FASTLAT = 8;
`endif

  logic         clk;
  logic         rstn;
  logic [255:0] datax;
  logic [255:0] datay;
  logic         update;
  logic [255:0] dataz;
  logic         done;
  logic         busy;

  typedef struct {
    logic [255:0] z;
    int           acc;
    int           lat;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  sub256mod #(.modz(N)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .datax  (datax),
    .datay  (datay),
    .update (update),
    .dataz  (dataz),
    .done   (done),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Wait (at falling edges) until the block is idle, bounded.
  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (i == 40) check("idle_timeout", 256'(busy), 256'd0);
  endtask

  // Issue one operation; expected result and no-borrow flag are hand-derived.
  task automatic run_op(input logic [255:0] x, input logic [255:0] y,
                        input logic [255:0] z, input bit noborrow, input string name);
    exp_t e;
    wait_idle();
    datax  = x;
    datay  = y;
    update = 1'b1;
    e.z = z; e.acc = cyc + 1; e.lat = noborrow ? FASTLAT : 8; e.name = name;
    q.push_back(e);
    @(negedge clk);
    update = 1'b0;
    check({"busy_", name}, 256'(busy), 256'd1);
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks hold otherwise
  initial begin
    exp_t         e;
    logic [255:0] last_z;
    last_z = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_z = '0;
      end else if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 256'(done), 256'd0);
        end else begin
          e = q.pop_front();
          check({"z_", e.name}, dataz, e.z);
          check({"lat_", e.name}, 256'(cyc - e.acc), 256'(e.lat));
          last_z = e.z;
        end
      end else begin
        check("hold", dataz, last_z);
      end
    end
  end

  initial begin
    exp_t e;
    int   i;
    rstn   = 1'b0;
    update = 1'b0;
    datax  = '0;
    datay  = '0;
    #1;
    check("rst_dataz", dataz, 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    run_op(256'd5, 256'd3, 256'd2, 1'b1, "5m3");
    run_op(256'd3, 256'd5, N2, 1'b0, "3m5");
    run_op(N1, N1, 256'd0, 1'b1, "n1mn1");
    run_op(256'd0, N1, 256'd1, 1'b0, "0mn1");
    run_op({192'd0, 64'd1, 64'd0} >> 0, 256'd1, 256'h0000000000000000_0000000000000000_0000000000000000_FFFFFFFFFFFFFFFF, 1'b1, "limbborrow");
    run_op(256'd0, {256{1'b1}}, NP1, 1'b0, "outrange");

    // Back-to-back: second accepted on the edge right after the first done
    run_op(N1, 256'd1, N2, 1'b1, "b2b_a");
    run_op(256'd1, N1, 256'd2, 1'b0, "b2b_b");

    // update held high across an operation while operands change underneath
    wait_idle();
    datax  = 256'd100;
    datay  = 256'd1;
    update = 1'b1;
    e.z = 256'd99; e.acc = cyc + 1; e.lat = FASTLAT; e.name = "hold_a";
    q.push_back(e);
    @(negedge clk);
    datax = {256{1'b1}};
    datay = 256'h1234;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 20) check("hold_timeout", 256'(done), 256'd1);
    datax = 256'd1;
    datay = 256'd2;
    e.z = N1; e.acc = cyc + 1; e.lat = 8; e.name = "hold_b";
    q.push_back(e);
    @(negedge clk);
    update = 1'b0;
    check("busy_hold_b", 256'(busy), 256'd1);

    // Reset during SUB limb 2 aborts without a done pulse
    wait_idle();
    datax  = 256'd9;
    datay  = 256'd11;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_dataz", dataz, 256'd0);
    check("abort_done", 256'(done), 256'd0);
    check("abort_busy", 256'(busy), 256'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    datax  = 256'd7;
    datay  = 256'd2;
    update = 1'b1;
    e.z = 256'd5; e.acc = cyc + 1; e.lat = FASTLAT; e.name = "after_rst";
    q.push_back(e);
    @(negedge clk);
    update = 1'b0;
    check("busy_after_rst", 256'(busy), 256'd1);

    // Drain the scoreboard, then idle a little to catch stray pulses
    for (i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 256'(q.size()), 256'd0);
    repeat (12) @(negedge clk);
    check("final_busy", 256'(busy), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub256mod.md
SUB256MOD -- requirements
Module: sub256mod

Interface
REQ-001 SHALL have parameter modz, default 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141 (the secp256k1 order n), which is the modulus.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port datax, input, 256 bits: minuend, sampled only on the accepting edge.
REQ-005 SHALL have port datay, input, 256 bits: subtrahend, sampled only on the accepting edge.
REQ-006 SHALL have port update, input, 1 bit: start request.
REQ-007 SHALL have port dataz, output, 256 bits, registered: result (datax - datay) mod modz.
REQ-008 SHALL have port done, output, 1 bit, registered: one-cycle result-valid pulse.
REQ-009 SHALL have port busy, output, 1 bit, registered: high while an operation is in progress.

Function
REQ-010 SHALL implement FSM states IDLE, SUB, CORR.
REQ-011 In IDLE with update=1, the rising edge (the accepting edge) SHALL latch datax and datay, clear the limb counter and borrow, set busy=1, and enter SUB.
REQ-012 SUB SHALL process one 64-bit limb per cycle, LSB limb first (limbs 0..3), computing x_i - y_i - borrow and storing the limb and the new borrow; after limb 3 it SHALL enter CORR.
REQ-013 CORR SHALL process one 64-bit limb per cycle, LSB first, adding (final SUB borrow ? modz limb : 0) plus carry; the carry out of limb 3 SHALL be discarded (256-bit truncation).
REQ-014 On the edge completing CORR limb 3, dataz SHALL load the full result, done SHALL be 1 for exactly one cycle, busy SHALL drop to 0, and the FSM SHALL return to IDLE.
REQ-015 Latency: done SHALL be high in the cycle following the 8th rising edge after the accepting edge; throughput is one operation per 9 cycles.
REQ-016 dataz SHALL change only on the done-setting edge; between results it SHALL hold the last value.
REQ-017 update SHALL be ignored while busy=1 and on the done-setting edge; a new operation SHALL be accepted no earlier than the edge after done rises.
REQ-018 Operands are specified as less than modz; for other operands the output SHALL still equal (x - y + (borrow ? modz : 0)) mod 2^256, with no error indication.

Reset
REQ-019 rstn=0 SHALL immediately force state IDLE, dataz=0, done=0, busy=0, and clear the limb counter, borrow/carry, and operand registers, regardless of clock.
REQ-020 Reset asserted mid-operation SHALL abort it without producing a done pulse; after release, the block SHALL accept update on the first edge.

Configuration
REQ-021 With macro SUB256MOD_FASTPATH_EN defined, the FSM SHALL skip CORR when the final SUB borrow=0, loading dataz and pulsing done on the 4th rising edge after the accepting edge; when borrow=1, timing SHALL be as in REQ-015.
REQ-022 Without SUB256MOD_FASTPATH_EN, latency SHALL be a fixed 8 edges for all operands.

Verification
REQ-023 x=5, y=3 -> dataz=2, done pulse one cycle, 8 edges after accept (4 edges with FASTPATH_EN).
REQ-024 x=3, y=5 -> dataz=modz-2=...BFD25E8C_D036413F, 8 edges after accept in both configurations.
REQ-025 x=y=modz-1 -> dataz=0; x=0, y=modz-1 -> dataz=1.
REQ-026 update held high continuously from accept through done, with datax/datay changed mid-op -> result uses the accepted operands; next accept occurs on the edge after done.
REQ-027 rstn pulsed low at SUB limb 2 -> done stays 0, dataz=0, busy=0; a following operation x=7, y=2 -> dataz=5.
REQ-028 Back-to-back x=modz-1, y=1 then x=1, y=modz-1 -> dataz=modz-2 then dataz=2, each with exactly one done pulse.
